// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word addresses to a synchronous-read
// instruction memory, tracks the one-cycle read latency and registers the
// returned word with its PC into the IF/ID register. Supports decode stall
// (replay of the in-flight address) and branch/jump redirect with squash.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid
);

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

    // Next address to issue and the address whose data is on imem_data
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] f1_pc;
    logic                  f1_valid;

    // Address mux: stall replays f1_pc so the memory keeps returning the same word
    always_comb begin
        imem_addr = pc_q;
        if (redirect_valid) begin
            imem_addr = redirect_addr;
        end else if (stall) begin
            imem_addr = f1_pc;
        end
    end

    // Fetch pipeline update: rst > redirect > stall > normal advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= PC_INIT;
            f1_pc       <= '0;
            f1_valid    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc_q        <= redirect_addr + PC_ONE;
            f1_pc       <= redirect_addr;
            f1_valid    <= 1'b1;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            pc_q        <= pc_q + PC_ONE;
            f1_pc       <= pc_q;
            f1_valid    <= 1'b1;
            instr       <= imem_data;
            instr_pc    <= f1_pc;
            instr_valid <= f1_valid;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch with a synchronous
// instruction memory model holding 0xA0000000 + address at each word.
module tb_instruction_fetch;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] RPC = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data is the word at the address sampled last edge
    always @(posedge clk) imem_data <= 32'hA000_0000 + 32'(imem_addr);

    typedef struct {
        logic          valid;
        logic          known;
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } exp_t;

    exp_t exp_q[$];

    // Stream-level reference: what decode should see after each edge
    logic          m_valid = 1'b0;
    logic          m_known = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic [DW-1:0] m_ins = '0;
    logic [AW-1:0] m_next = '0;
    int            m_wait = 0;
    bit            m_init = 1'b0;
    bit            drive_done = 1'b0;

    function automatic logic [AW-1:0] exp_addr(input logic st, input logic rv,
                                               input logic [AW-1:0] ra);
        if (rv) return ra;
        if (st) return (m_wait == 0) ? m_next : '0;
        return (m_wait == 0) ? AW'(m_next + AW'(1)) : m_next;
    endfunction

    task automatic model_step(input logic r, input logic st, input logic rv,
                              input logic [AW-1:0] ra);
        exp_t e;
        if (r) begin
            m_valid = 1'b0; m_known = 1'b1; m_pc = '0; m_ins = '0;
            m_next = RPC; m_wait = 1; m_init = 1'b1;
        end else if (rv) begin
            m_valid = 1'b0; m_next = ra; m_wait = 0;
        end else if (st) begin
            // everything holds
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1; m_valid = 1'b0; m_known = 1'b0;
        end else begin
            m_valid = 1'b1; m_known = 1'b1; m_pc = m_next;
            m_ins = 32'hA000_0000 + 32'(m_next);
            m_next = AW'(m_next + AW'(1));
        end
        e.valid = m_valid; e.known = m_known; e.pc = m_pc; e.ins = m_ins;
        exp_q.push_back(e);
    endtask

    // Drive one cycle on the falling edge, check the address mux, record expectation
    task automatic cyc(input logic r, input logic st, input logic rv,
                       input logic [AW-1:0] ra);
        logic [AW-1:0] ea;
        @(negedge clk);
        rst = r; stall = st; redirect_valid = rv; redirect_addr = ra;
        #1;
        if (m_init) begin
            ea = exp_addr(st, rv, ra);
            n_cmp++;
            if (imem_addr !== ea) begin
                n_bad++;
                $display("FAIL imem_addr t=%0t got %h want %h (stall=%b rv=%b)",
                         $time, imem_addr, ea, st, rv);
            end
        end
        model_step(r, st, rv, ra);
    endtask

    // Monitor: pop one expectation per edge and compare the IF/ID register
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (instr_valid !== e.valid) begin
                n_bad++;
                $display("FAIL instr_valid t=%0t got %b want %b", $time, instr_valid, e.valid);
            end
            if (e.valid || e.known) begin
                n_cmp++;
                if (instr_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL instr_pc t=%0t got %h want %h", $time, instr_pc, e.pc);
                end
                n_cmp++;
                if (instr !== e.ins) begin
                    n_bad++;
                    $display("FAIL instr t=%0t got %h want %h", $time, instr, e.ins);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset for two cycles then stream from RESET_PC
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        guard = 0;
        while (!(m_valid && m_pc == 10'd5) && guard < 50) begin
            cyc(0, 0, 0, '0); guard++;
        end
        // Stall while instr_pc=5, then resume
        repeat (3) cyc(0, 1, 0, '0);
        repeat (3) cyc(0, 0, 0, '0);
        // Plain redirect, then redirect colliding with stall
        cyc(0, 0, 1, 10'h200);
        repeat (3) cyc(0, 0, 0, '0);
        cyc(0, 1, 1, 10'h100);
        repeat (3) cyc(0, 0, 0, '0);
        // Redirect to the top word to exercise wrap-around
        cyc(0, 0, 1, 10'h3FF);
        repeat (3) cyc(0, 0, 0, '0);
        // Reset mid-stream at instr_pc=0x12
        guard = 0;
        while (!(m_valid && m_pc == 10'h12) && guard < 50) begin
            cyc(0, 0, 0, '0); guard++;
        end
        cyc(1, 0, 0, '0);
        repeat (4) cyc(0, 0, 0, '0);
        // Random mix, including redirects during reset and stall during bubbles
        for (int i = 0; i < 3000; i++) begin
            logic r, st, rv;
            logic [AW-1:0] ra;
            r  = ($urandom_range(0, 99) < 2);
            rv = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom);
            cyc(r, st, rv, ra);
        end
        cyc(0, 0, 0, '0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
